fp_mant_addsub_pipe: RTL and testbench

Parametrised, two-stage pipelined sign-magnitude mantissa adder/subtractor for the FP adder datapath. It sits after exponent alignment and before normalisation. It takes two signed aligned mantissas plus an explicit subtract mode and produces the result sign, carry-out, magnitude, zero flag and leading-zero count. The normaliser consumes these directly. Valid/ready handshakes on both sides allow the stage to stall.

---
 rtl/fp_mant_addsub_pipe.sv | 107 ++++++++++
 tb/tb_fp_mant_addsub_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mant_addsub_pipe.sv
// Two-stage sign-magnitude mantissa adder/subtractor feeding the FP normaliser.
// Stage 1 forms sign/carry/magnitude; stage 2 adds zero flag and leading-zero count.
module fp_mant_addsub_pipe #(
  parameter int MW  = 27,
  parameter int LZW = $clog2(MW + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sub,
  input  logic           in_s1,
  input  logic           in_s2,
  input  logic [MW-1:0]  in_m1,
  input  logic [MW-1:0]  in_m2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_s,
  output logic           out_c,
  output logic [MW-1:0]  out_m,
  output logic           out_zero,
  output logic [LZW-1:0] out_lzc
);

  logic           v1, v2;
  logic           ready1, ready2;
  logic           take_in, move;
  logic           s2e, eff_add;
  logic [MW:0]    r;
  logic           s_nxt;
  logic           st1_s, st1_c;
  logic [MW-1:0]  st1_m;
  logic           zero1;
  logic [LZW-1:0] lzc1;

  assign ready2    = !v2 || out_ready;
  assign ready1    = !v1 || ready2;
  assign in_ready  = ready1;
  assign take_in   = in_valid && ready1;
  assign move      = v1 && ready2;
  assign out_valid = v2;

  assign s2e     = in_s2 ^ in_sub;
  assign eff_add = (in_s1 == s2e);

  // Equal-magnitude subtract falls through to the defaults: forced +0.
  always_comb begin
    r     = '0;
    s_nxt = 1'b0;
    if (eff_add) begin
      r     = {1'b0, in_m1} + {1'b0, in_m2};
      s_nxt = in_s1;
    end else if (in_m1 > in_m2) begin
      r     = {1'b0, in_m1 - in_m2};
      s_nxt = in_s1;
    end else if (in_m2 > in_m1) begin
      r     = {1'b0, in_m2 - in_m1};
      s_nxt = s2e;
    end
  end

  assign zero1 = !st1_c && (st1_m == '0);

  // Ascending scan: the highest set bit is the last one to write lzc1.
  always_comb begin
    lzc1 = LZW'(MW);
    for (int unsigned i = 0; i < MW; i++) begin
      if (st1_m[i]) lzc1 = LZW'(MW - 1 - i);
    end
    if (st1_c) lzc1 = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      st1_s    <= 1'b0;
      st1_c    <= 1'b0;
      st1_m    <= '0;
      out_s    <= 1'b0;
      out_c    <= 1'b0;
      out_m    <= '0;
      out_zero <= 1'b0;
      out_lzc  <= '0;
    end else begin
      if (take_in) begin
        v1    <= 1'b1;
        st1_s <= s_nxt;
        st1_c <= r[MW];
        st1_m <= r[MW-1:0];
      end else if (move) begin
        v1 <= 1'b0;
      end
      if (move) begin
        v2       <= 1'b1;
        out_s    <= st1_s;
        out_c    <= st1_c;
        out_m    <= st1_m;
        out_zero <= zero1;
        out_lzc  <= lzc1;
      end else if (out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_mant_addsub_pipe.sv
// Directed-vector bench for fp_mant_addsub_pipe: hand-computed results,
// latency/throughput, backpressure with stall stability, async reset flush.
module tb_fp_mant_addsub_pipe;

  localparam int MW  = 27;
  localparam int LZW = $clog2(MW + 1);
  localparam int NV  = 10;

  logic           clk, rst_n;
  logic           in_valid, in_ready, in_sub, in_s1, in_s2;
  logic [MW-1:0]  in_m1, in_m2;
  logic           out_valid, out_ready, out_s, out_c, out_zero;
  logic [MW-1:0]  out_m;
  logic [LZW-1:0] out_lzc;

  fp_mant_addsub_pipe #(.MW(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_s1(in_s1), .in_s2(in_s2), .in_m1(in_m1), .in_m2(in_m2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_c(out_c), .out_m(out_m),
    .out_zero(out_zero), .out_lzc(out_lzc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Vector table: stimulus and hand-computed expected results.
  logic          vsub[NV], vs1[NV], vs2[NV];
  logic [MW-1:0] vm1[NV], vm2[NV];
  logic          es[NV], ec[NV], ez[NV];
  logic [MW-1:0] em[NV];
  int            el[NV];

  task automatic setv(input int i, input logic sub, input logic s1, input logic s2,
                      input logic [MW-1:0] m1, input logic [MW-1:0] m2,
                      input logic s, input logic c, input logic [MW-1:0] m,
                      input logic z, input int l);
    vsub[i] = sub; vs1[i] = s1; vs2[i] = s2; vm1[i] = m1; vm2[i] = m2;
    es[i] = s; ec[i] = c; em[i] = m; ez[i] = z; el[i] = l;
  endtask

  int cur = 0;
  int q[$];
  logic           stalled = 1'b0;
  logic           snap_s, snap_c, snap_z;
  logic [MW-1:0]  snap_m;
  logic [LZW-1:0] snap_l;

  // Monitor: sample between edges; decide what the next rising edge transfers.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (out_valid && stalled) begin
        chk("stall_s", out_s, snap_s);
        chk("stall_c", out_c, snap_c);
        chk("stall_m", out_m, snap_m);
        chk("stall_z", out_zero, snap_z);
        chk("stall_lzc", out_lzc, snap_l);
      end
      stalled = out_valid && !out_ready;
      snap_s = out_s; snap_c = out_c; snap_m = out_m; snap_z = out_zero; snap_l = out_lzc;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          int k;
          k = q.pop_front();
          chk($sformatf("v%0d_s", k), out_s, es[k]);
          chk($sformatf("v%0d_c", k), out_c, ec[k]);
          chk($sformatf("v%0d_m", k), out_m, em[k]);
          chk($sformatf("v%0d_zero", k), out_zero, ez[k]);
          chk($sformatf("v%0d_lzc", k), out_lzc, el[k]);
        end
      end
      if (in_valid && in_ready) q.push_back(cur);
    end
  end

  task automatic drive(input int i);
    cur      = i;
    in_valid = 1'b1;
    in_sub   = vsub[i];
    in_s1    = vs1[i];
    in_s2    = vs2[i];
    in_m1    = vm1[i];
    in_m2    = vm2[i];
  endtask

  task automatic send(input int i);
    logic acc;
    acc = 1'b0;
    drive(i);
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    chk("drain", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    setv(0, 0, 0, 0, 27'h4000000, 27'h4000000, 0, 1, 27'h0000000, 0, 0);
    setv(1, 1, 0, 0, 27'h0000100, 27'h0000300, 1, 0, 27'h0000200, 0, 17);
    setv(2, 0, 1, 0, 27'h1234567, 27'h1234567, 0, 0, 27'h0000000, 1, 27);
    setv(3, 0, 0, 0, 27'h0000001, 27'h0000002, 0, 0, 27'h0000003, 0, 25);
    setv(4, 0, 1, 1, 27'h7FFFFFF, 27'h0000001, 1, 1, 27'h0000000, 0, 0);
    setv(5, 1, 1, 0, 27'h0000010, 27'h0000001, 1, 0, 27'h0000011, 0, 22);
    setv(6, 1, 0, 1, 27'h5000000, 27'h1000000, 0, 0, 27'h6000000, 0, 0);
    setv(7, 0, 0, 1, 27'h0000000, 27'h0000005, 1, 0, 27'h0000005, 0, 24);
    setv(8, 0, 1, 0, 27'h2000000, 27'h0000001, 1, 0, 27'h1FFFFFF, 0, 2);
    setv(9, 1, 0, 0, 27'h0000000, 27'h0000000, 0, 0, 27'h0000000, 1, 27);

    in_valid = 1'b0; in_sub = 1'b0; in_s1 = 1'b0; in_s2 = 1'b0;
    in_m1 = '0; in_m2 = '0; out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 32'd0);
    chk("rst_outs", {out_s, out_c, out_zero}, 32'd0);
    chk("rst_m", out_m, 32'd0);
    chk("rst_lzc", out_lzc, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 32'd1);

    // Latency: driven after edge E0, accepted at E1, valid after E2.
    for (int i = 0; i < 3; i++) begin
      send(i);
      chk("lat_early", out_valid, 32'd0);
      @(posedge clk);
      #1;
      chk("lat_valid", out_valid, 32'd1);
      drain();
    end

    // Backpressure: 4 ops offered while the consumer stalls for 5 cycles.
    out_ready = 1'b0;
    idx = 3;
    for (int c = 0; c < 5; c++) begin
      drive(idx);
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", idx - 3, 32'd2);
    chk("bp_full_ready", in_ready, 32'd0);
    out_ready = 1'b1;
    for (int t = 0; t < 40 && idx < 7; t++) begin
      drive(idx);
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", idx, 32'd7);
    drain();

    // Throughput: 8 back-to-back ops, out_valid high for exactly 8 cycles.
    for (int j = 0; j <= 10; j++) begin
      chk($sformatf("tp_valid_%0d", j), out_valid, (j >= 2 && j <= 9) ? 32'd1 : 32'd0);
      if (j < 8) begin
        chk("tp_ready", in_ready, 32'd1);
        drive(2 + j);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    drain();

    // Async reset with both stages occupied.
    out_ready = 1'b0;
    send(5);
    send(6);
    chk("pre_rst_full", in_ready, 32'd0);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", out_valid, 32'd0);
    chk("mid_rst_outs", {out_s, out_c, out_zero}, 32'd0);
    chk("mid_rst_m", out_m, 32'd0);
    chk("mid_rst_lzc", out_lzc, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 32'd1);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("post_rst_stale", out_valid, 32'd0);
    end
    @(posedge clk);
    #1;
    send(8);
    chk("post_rst_early", out_valid, 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_valid", out_valid, 32'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
